// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: datapath widths and the result-broadcast entry
// used by the reservation station, ROB and the CDB arbiter.
package cpu_pkg;

  localparam int NUM_FU = 3;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 6;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  rob;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result FIFO: DEPTH entries of cdb_entry_t, extra-MSB pointers for
// full/empty, synchronous flush that empties it without touching storage.
module cdb_result_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  cdb_entry_t             push_data,
  output cdb_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  cdb_entry_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity,
  // and leaving the array out of reset lets it map onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining per-FU result FIFOs onto a registered
// wakeup/common-data-bus, one broadcast per cycle.
module cdb_arbiter
  import cpu_pkg::cdb_entry_t;
  import cpu_pkg::TAG_W;
  import cpu_pkg::DATA_W;
  import cpu_pkg::ROB_W;
#(
  parameter int               NUM_FU   = 3,
  parameter int               DEPTH    = 2,
  parameter logic [TAG_W-1:0] IDLE_TAG = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_val,
  input  logic [NUM_FU*ROB_W-1:0]  fu_rob,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     wakeup_valid,
  output logic [TAG_W-1:0]         wakeup_tag,
  output logic [DATA_W-1:0]        wakeup_val,
  output logic [ROB_W-1:0]         wakeup_rob,
  output logic [1:0]               wakeup_fu,
  output logic                     overflow_err
);

  localparam int FU_W  = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t        push_data [NUM_FU];
  cdb_entry_t        head      [NUM_FU];
  logic [CNT_W-1:0]  count     [NUM_FU];
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;

  logic              grant_valid;
  logic [FU_W-1:0]   grant_idx;
  cdb_entry_t        grant_entry;
  logic [FU_W-1:0]   rr_ptr;
  logic [FU_W-1:0]   rr_next;
  logic [FU_W:0]     search_sum;
  logic [FU_W-1:0]   search_idx;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign push_data[i] = '{tag: fu_tag[i*TAG_W +: TAG_W],
                            val: fu_val[i*DATA_W +: DATA_W],
                            rob: fu_rob[i*ROB_W +: ROB_W]};
    // Ready comes from registered occupancy only, so a full FIFO refuses a
    // push even in the cycle it is being drained.
    assign fu_ready[i]  = (count[i] != CNT_W'(DEPTH));
    assign push[i]      = fu_valid[i] && fu_ready[i] && !flush;
    assign pop[i]       = grant_valid && (grant_idx == FU_W'(i)) && !flush;

    cdb_result_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data (push_data[i]),
      .head      (head[i]),
      .count     (count[i]),
      .empty     (empty[i])
    );
  end

  // NOTE: every output of this block gets a default before the search loop;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_entry = '0;
    search_sum  = '0;
    search_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      search_sum = {1'b0, rr_ptr} + (FU_W+1)'(k);
      if (search_sum >= (FU_W+1)'(NUM_FU)) search_sum = search_sum - (FU_W+1)'(NUM_FU);
      search_idx = search_sum[FU_W-1:0];
      if (!grant_valid && !empty[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
        grant_entry = head[search_idx];
      end
    end
  end

  assign rr_next = (grant_idx == FU_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      wakeup_valid <= 1'b0;
      wakeup_tag   <= IDLE_TAG;
      wakeup_val   <= '0;
      wakeup_rob   <= '0;
      wakeup_fu    <= '0;
      overflow_err <= 1'b0;
    end else begin
      // Pushes squashed by flush are discarded silently, not as overflow.
      if (!flush && |(fu_valid & ~fu_ready)) overflow_err <= 1'b1;

      if (!flush && grant_valid) begin
        rr_ptr       <= rr_next;
        wakeup_valid <= 1'b1;
        wakeup_tag   <= grant_entry.tag;
        wakeup_val   <= grant_entry.val;
        wakeup_rob   <= grant_entry.rob;
        wakeup_fu    <= grant_idx;
      end else begin
        wakeup_valid <= 1'b0;
        wakeup_tag   <= IDLE_TAG;
        wakeup_val   <= '0;
        wakeup_rob   <= '0;
        wakeup_fu    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized + directed bench for cdb_arbiter against a queue-based model of
// per-FU result buffers and a rotating-priority broadcast slot.
module tb_cdb_arbiter;
  import cpu_pkg::*;

  localparam int             N        = 3;
  localparam int             DEPTH    = 2;
  localparam logic [5:0]     IDLE_TAG = 6'd0;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic [N-1:0]      fu_valid;
  logic [N*6-1:0]    fu_tag;
  logic [N*32-1:0]   fu_val;
  logic [N*6-1:0]    fu_rob;
  logic [N-1:0]      fu_ready;
  logic              wakeup_valid;
  logic [5:0]        wakeup_tag;
  logic [31:0]       wakeup_val;
  logic [5:0]        wakeup_rob;
  logic [1:0]        wakeup_fu;
  logic              overflow_err;

  cdb_arbiter #(.NUM_FU(N), .DEPTH(DEPTH), .IDLE_TAG(IDLE_TAG)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_tag       (fu_tag),
    .fu_val       (fu_val),
    .fu_rob       (fu_rob),
    .fu_ready     (fu_ready),
    .wakeup_valid (wakeup_valid),
    .wakeup_tag   (wakeup_tag),
    .wakeup_val   (wakeup_val),
    .wakeup_rob   (wakeup_rob),
    .wakeup_fu    (wakeup_fu),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per FU, a rotating start index, expected bus.
  cdb_entry_t  mq [N][$];
  int          m_rr;
  logic        m_ovf;
  logic        e_v;
  logic [5:0]  e_tag;
  logic [31:0] e_val;
  logic [5:0]  e_rob;
  int          e_fu;

  logic [5:0]  d_tag [N];
  logic [31:0] d_val [N];
  logic [5:0]  d_rob [N];

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      d_tag[i] = 6'($urandom_range(1, 63));
      d_val[i] = $urandom;
      d_rob[i] = 6'($urandom);
    end
  endtask

  task automatic model_idle();
    e_v = 1'b0; e_tag = IDLE_TAG; e_val = '0; e_rob = '0; e_fu = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr  = 0;
    m_ovf = 1'b0;
    model_idle();
  endtask

  task automatic check_outputs();
    check("wakeup_valid", 64'(wakeup_valid), 64'(e_v));
    check("wakeup_tag",   64'(wakeup_tag),   64'(e_tag));
    check("wakeup_val",   64'(wakeup_val),   64'(e_val));
    check("wakeup_rob",   64'(wakeup_rob),   64'(e_rob));
    check("wakeup_fu",    64'(wakeup_fu),    64'(e_fu));
    check("overflow_err", 64'(overflow_err), 64'(m_ovf));
  endtask

  // Called at posedge+1; applies inputs, checks ready, advances one edge.
  task automatic step(input logic [N-1:0] v, input logic fl);
    logic [N-1:0] exp_ready;
    cdb_entry_t   e;
    int           g;
    int           idx;
    fu_valid = v;
    flush    = fl;
    for (int i = 0; i < N; i++) begin
      fu_tag[i*6 +: 6]   = d_tag[i];
      fu_val[i*32 +: 32] = d_val[i];
      fu_rob[i*6 +: 6]   = d_rob[i];
      exp_ready[i]       = (mq[i].size() < DEPTH);
    end
    #1;
    check("fu_ready", 64'(fu_ready), 64'(exp_ready));
    if (fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      model_idle();
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        e     = mq[g].pop_front();
        e_v   = 1'b1; e_tag = e.tag; e_val = e.val; e_rob = e.rob; e_fu = g;
        m_rr  = (g + 1) % N;
      end else begin
        model_idle();
      end
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          if (exp_ready[i]) mq[i].push_back('{tag: d_tag[i], val: d_val[i], rob: d_rob[i]});
          else              m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Async reset mid-cycle; outputs must be idle before the next edge.
  task automatic do_reset();
    #2;
    reset_n  = 1'b0;
    fu_valid = '0;
    flush    = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("reset_ready", 64'(fu_ready), 64'(3'b111));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_val   = '0;
    fu_rob   = '0;
    model_reset();
    rand_data();
    #12;
    check_outputs();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push from FU1.
    d_tag[1] = 6'd12; d_val[1] = 32'hDEAD_BEEF; d_rob[1] = 6'd5;
    step(3'b010, 1'b0);
    step(3'b000, 1'b0);
    check("single_tag", 64'(wakeup_tag), 64'(6'd12));
    check("single_val", 64'(wakeup_val), 64'(32'hDEAD_BEEF));
    check("single_fu",  64'(wakeup_fu),  64'(2'd1));
    step(3'b000, 1'b0);
    check("single_idle", 64'(wakeup_valid), 64'(1'b0));

    // Bring the rotation back to FU0, then three-way contention.
    rand_data();
    step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    d_tag[0] = 6'd10; d_tag[1] = 6'd11; d_tag[2] = 6'd12;
    step(3'b111, 1'b0);
    step(3'b000, 1'b0);
    check("cont_tag0", 64'(wakeup_tag), 64'(6'd10));
    step(3'b000, 1'b0);
    check("cont_tag1", 64'(wakeup_tag), 64'(6'd11));
    step(3'b000, 1'b0);
    check("cont_tag2", 64'(wakeup_tag), 64'(6'd12));
    step(3'b000, 1'b0);

    // Reset while FIFOs hold entries.
    rand_data(); step(3'b111, 1'b0);
    rand_data(); step(3'b111, 1'b0);
    do_reset();

    // Fill/backpressure on FU0 with FU1/FU2 loaded.
    rand_data(); step(3'b110, 1'b0);
    rand_data(); step(3'b110, 1'b0);
    for (int c = 0; c < 6; c++) begin
      rand_data(); step(3'b001, 1'b0);
    end
    check("overflow_set", 64'(overflow_err), 64'(1'b1));
    for (int c = 0; c < 6; c++) step(3'b000, 1'b0);

    // Flush with four entries buffered and a concurrent FU2 push.
    rand_data(); step(3'b111, 1'b0);
    rand_data(); step(3'b110, 1'b0);
    rand_data(); step(3'b100, 1'b1);
    check("flush_idle", 64'(wakeup_valid), 64'(1'b0));
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    check("flush_drained", 64'(wakeup_valid), 64'(1'b0));

    // Pointer wrap: nine results streamed through FU2 alone.
    for (int c = 0; c < 9; c++) begin
      rand_data(); step(3'b100, 1'b0);
    end
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);

    // Random traffic with occasional flushes and one reset.
    for (int c = 0; c < 400; c++) begin
      rand_data();
      if (c == 200) do_reset();
      step(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom),
           ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
